// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Optional divide support is enabled with MULDIV_DIV_EN.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    MULT   = 4'd1,
    MULTU  = 4'd2,
    MADD   = 4'd3,
    MSUB   = 4'd4,
    MTHI   = 4'd5,
    MTLO   = 4'd6,
    DIV    = 4'd7,
    DIVU   = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIN
  } state_e;

  function automatic logic is_long(input op_e op);
    case (op)
      MULT, MULTU, MADD, MSUB: is_long = 1'b1;
`ifdef MULDIV_DIV_EN
      DIV, DIVU: is_long = 1'b1;
`endif
      default: is_long = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed(input op_e op);
    case (op)
      MULT, MADD, MSUB: is_signed = 1'b1;
`ifdef MULDIV_DIV_EN
      DIV: is_signed = 1'b1;
`endif
      default: is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier, plus a restoring
// divide step when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int RADIX_BITS = 1
) (
`ifdef MULDIV_DIV_EN
  input  logic               div,
`endif
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   y_nxt
);

  logic [2*WIDTH-1:0] a;
  logic [WIDTH-1:0]   q;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     r;
`endif

  // y is consumed MSB first; for divide it is the dividend and
  // collects quotient bits from the bottom.
  always_comb begin
    a = acc;
    q = y;
`ifdef MULDIV_DIV_EN
    r = '0;
`endif
    for (int i = 0; i < RADIX_BITS; i++) begin
`ifdef MULDIV_DIV_EN
      if (div) begin
        r = {a[WIDTH-1:0], q[WIDTH-1]};
        q = q << 1;
        if (r >= {1'b0, x}) begin
          r    = r - {1'b0, x};
          q[0] = 1'b1;
        end
        a = {{WIDTH{1'b0}}, r[WIDTH-1:0]};
      end else
`endif
      begin
        a = a << 1;
        if (q[WIDTH-1])
          a = a + {{WIDTH{1'b0}}, x};
        q = q << 1;
      end
    end
    acc_nxt = a;
    y_nxt   = q;
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner: iterative MULT/MULTU/MADD/MSUB sequencer, MTHI/MTLO.
// Define MULDIV_DIV_EN to add DIV/DIVU on the same datapath.
module hilo_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int RADIX_BITS = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             RdHiLo,
  output logic             Ready,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;

  state_e           state;
  op_e              opq;
  op_e              op_in;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] absa;
  logic [WIDTH-1:0] absb;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    acc_nxt;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    fin;
  logic [CW-1:0]    cnt;
  logic             sa;
  logic             sb;
  logic             sgn;

  assign op_in = op_e'(Op);
  assign Ready = (state == IDLE);
  assign Stall = RdHiLo & (state != IDLE);
  assign sgn   = is_signed(opq);

  // Unsigned WIDTH-bit magnitude is exact even for the most
  // negative input, since 2^(WIDTH-1) fits unsigned.
  assign absa = (sgn & xr[WIDTH-1]) ? -xr : xr;
  assign absb = (sgn & yr[WIDTH-1]) ? -yr : yr;

  muldiv_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .div     (opq == DIV || opq == DIVU),
`endif
    .acc     (acc),
    .x       (xr),
    .y       (yr),
    .acc_nxt (acc_nxt),
    .y_nxt   (y_nxt)
  );

  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    fin  = prod;
    case (opq)
      MADD: fin = {Hi, Lo} + prod;
      MSUB: fin = {Hi, Lo} - prod;
`ifdef MULDIV_DIV_EN
      DIV, DIVU: begin
        if (xr == '0)
          fin[WIDTH-1:0] = {WIDTH{1'b1}};
        else
          fin[WIDTH-1:0] = (sa ^ sb) ? -yr : yr;
        fin[W2-1:WIDTH] = sa ? -acc[WIDTH-1:0]
                             : acc[WIDTH-1:0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      opq   <= OP_NOP;
      xr    <= '0;
      yr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              if (is_long(op_in)) begin
                state <= PREP;
                opq   <= op_in;
                xr    <= A;
                yr    <= B;
              end else begin
                Done <= 1'b1;
                if (op_in == MTHI)
                  Hi <= A;
                else if (op_in == MTLO)
                  Lo <= A;
              end
            end
          end
          PREP: begin
            // x = |B| (multiplicand/divisor), y = |A|
            sa    <= sgn & xr[WIDTH-1];
            sb    <= sgn & yr[WIDTH-1];
            xr    <= absb;
            yr    <= absa;
            acc   <= '0;
            cnt   <= CW'(N - 1);
            state <= ITER;
          end
          ITER: begin
            acc <= acc_nxt;
            yr  <= y_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
              state <= FIN;
          end
          FIN: begin
            {Hi, Lo} <= fin;
            Done     <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Scoreboard bench for hilo_muldiv_seq (WIDTH=32, RADIX_BITS=1).
// Divide cases run only when MULDIV_DIV_EN is defined.
module tb_hilo_muldiv_seq;
  import muldiv_pkg::*;

  localparam int N = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Flush = 1'b0;
  logic        RdHiLo = 1'b0;
  logic        Ready;
  logic        Done;
  logic        Stall;
  logic [31:0] Hi;
  logic [31:0] Lo;

  exp_t        q[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  hilo_muldiv_seq dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Flush   (Flush),
    .RdHiLo  (RdHiLo),
    .Ready   (Ready),
    .Done    (Done),
    .Stall   (Stall),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge Clk);
    cyc++;
    #1;
    if (Done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'(Done), 64'd0);
      end else begin
        e = q.pop_front();
        chk("hi", 64'(Hi), 64'(e.hi));
        chk("lo", 64'(Lo), 64'(e.lo));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++)
      tick();
    if (q.size() != 0) begin
      chk("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  function automatic logic [63:0] mprod(input op_e op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint x;
    longint y;
    if (op == MULTU)
      return {32'd0, a} * {32'd0, b};
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  task automatic issue_exp(input op_e op, input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [31:0] ehi,
                           input logic [31:0] elo, input int lat);
    exp_t e;
    for (int i = 0; i < 100 && !Ready; i++)
      tick();
    if (!Ready)
      chk("ready_timeout", 64'(Ready), 64'd1);
    mhi = ehi;
    mlo = elo;
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = cyc + lat;
    q.push_back(e);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic issue(input op_e op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] hl;
    logic [63:0] p;
    int          lat;
    p   = mprod(op, a, b);
    hl  = {mhi, mlo};
    lat = 1;
    case (op)
      MULT, MULTU: begin hl = p;      lat = N + 3; end
      MADD:        begin hl = hl + p; lat = N + 3; end
      MSUB:        begin hl = hl - p; lat = N + 3; end
      MTHI:        hl[63:32] = a;
      MTLO:        hl[31:0]  = a;
      default:     ;
    endcase
    issue_exp(op, a, b, hl[63:32], hl[31:0], lat);
  endtask

  initial begin
    logic [31:0] oh;
    logic [31:0] ol;
    op_e         rop;

    tick();
    tick();
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    chk("rst_ready", 64'(Ready), 64'd1);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    Reset_n = 1'b1;
    tick();

    // signed multiply; Start ignored and Stall while busy
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    Start  = 1'b1;
    Op     = MTHI;
    A      = 32'h1234;
    RdHiLo = 1'b1;
    #1;
    chk("stall_busy", 64'(Stall), 64'd1);
    chk("ready_busy", 64'(Ready), 64'd0);
    repeat (3) tick();
    chk("hold_hi", 64'(Hi), 64'd0);
    chk("hold_lo", 64'(Lo), 64'd0);
    Start  = 1'b0;
    RdHiLo = 1'b0;
    wait_idle();
    chk("mult_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFFFFEB);
    RdHiLo = 1'b1;
    #1;
    chk("stall_idle", 64'(Stall), 64'd0);
    RdHiLo = 1'b0;

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();

    // accumulate chain, issued back-to-back
    issue(MTHI, 32'd0, 32'd0);
    issue(MTLO, 32'd10, 32'd0);
    issue(MADD, 32'd2, 32'd3);
    wait_idle();
    chk("madd_lo", 64'(Lo), 64'h10);
    issue(MSUB, 32'd4, 32'd5);
    wait_idle();
    chk("msub_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("msub_lo", 64'(Lo), 64'hFFFFFFFC);

    issue(MULT, 32'h80000000, 32'h80000000);
    issue(MULT, 32'h80000000, 32'd1);
    issue(MULT, 32'h7FFFFFFF, 32'h80000000);
    wait_idle();

    // undefined ops behave as NOPs
    issue(op_e'(4'hF), 32'hDEAD, 32'hBEEF);
    issue(OP_NOP, 32'h55, 32'h66);
`ifndef MULDIV_DIV_EN
    issue(DIV, 32'd9, 32'd3);
    issue(DIVU, 32'd9, 32'd3);
`endif
    wait_idle();

    // flush mid-op
    oh = Hi;
    ol = Lo;
    Start = 1'b1;
    Op    = MULT;
    A     = 32'd123;
    B     = 32'd456;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_ready", 64'(Ready), 64'd1);
    repeat (40) tick();
    chk("flush_hi", 64'(Hi), 64'(oh));
    chk("flush_lo", 64'(Lo), 64'(ol));

    // flush beats start in idle
    Start = 1'b1;
    Op    = MTHI;
    A     = 32'hABCD;
    Flush = 1'b1;
    tick();
    Start = 1'b0;
    Flush = 1'b0;
    tick();
    chk("flush_start_hi", 64'(Hi), 64'(oh));

`ifdef MULDIV_DIV_EN
    issue_exp(DIV, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, N + 3);
    issue_exp(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, N + 3);
    issue_exp(DIV, 32'd100, 32'hFFFFFFF9,
              32'd2, 32'hFFFFFFF2, N + 3);
    wait_idle();
`endif

    for (int i = 0; i < 8; i++) begin
      rop = op_e'(4'(1 + $urandom_range(0, 3)));
      issue(rop, $urandom, $urandom);
    end
    wait_idle();

    // reset mid-op
    Start = 1'b1;
    Op    = MULTU;
    A     = 32'd77;
    B     = 32'd88;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    Reset_n = 1'b0;
    #1;
    chk("rmid_hi", 64'(Hi), 64'd0);
    chk("rmid_lo", 64'(Lo), 64'd0);
    chk("rmid_ready", 64'(Ready), 64'd1);
    chk("rmid_done", 64'(Done), 64'd0);
    mhi = '0;
    mlo = '0;
    tick();
    Reset_n = 1'b1;
    repeat (40) tick();
    chk("rpost_hi", 64'(Hi), 64'd0);

    issue(MADD, 32'hFFFFFFFF, 32'd1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
